// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with enable and flush-to-bubble
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            flush,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc,
    output logic [31:0]     id_instruction,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid
);

    // flush wins over a normal load so a redirect always leaves a bubble
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            id_instruction <= NOP_INSTR;
            id_pc          <= '0;
            id_valid       <= 1'b0;
        end else if (en) begin
            id_instruction <= instruction;
            id_pc          <= pc;
            id_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, run/halt FSM, fetch counter, IF/ID
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic [PC_W-1:0]  imem_pc,
    input  logic [31:0]      imem_instruction,
    output logic [31:0]      id_instruction,
    output logic [PC_W-1:0]  id_pc,
    output logic             id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc_q;
    logic            load;
    logic            flush;

    assign imem_pc = pc_q;

    always_comb begin
        load  = 1'b0;
        flush = 1'b0;
        case (state)
            ST_IDLE: flush = 1'b1;
            ST_RUN: begin
                flush = redirect_valid;
                load  = !redirect_valid && !stall;
            end
            ST_HALT: flush = redirect_valid || !stall;
            default: flush = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (load && fetch_count != {CNT_W{1'b1}})
                fetch_count <= fetch_count + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (!stall) begin
                        // EBREAK is latched into IF/ID but the PC parks on it
                        if (imem_instruction == EBREAK_INSTR) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc_q <= pc_q + PC_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        pc_q   <= redirect_pc;
                        halted <= 1'b0;
                        state  <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    if_id_reg #(
        .PC_W(PC_W)
    ) u_if_id (
        .clk            (clk),
        .reset          (reset),
        .en             (load),
        .flush          (flush),
        .instruction    (imem_instruction),
        .pc             (pc_q),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_valid       (id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset, start, stall, redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] imem_pc, imem_pc2;
    logic [31:0]     imem_instruction, imem_instruction2;
    logic [31:0]     id_instruction, id_instruction2;
    logic [PC_W-1:0] id_pc, id_pc2;
    logic            id_valid, id_valid2, halted, halted2;
    logic [15:0]     fetch_count;
    logic [1:0]      fetch_count2;

    logic [31:0] mem [0:(1<<PC_W)-1];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_fc   = 0;

    always #5 clk = ~clk;

    assign imem_instruction  = mem[imem_pc];
    assign imem_instruction2 = mem[imem_pc2];

    fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_pc(imem_pc), .imem_instruction(imem_instruction),
        .id_instruction(id_instruction), .id_pc(id_pc), .id_valid(id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_pc(imem_pc2), .imem_instruction(imem_instruction2),
        .id_instruction(id_instruction2), .id_pc(id_pc2), .id_valid(id_valid2),
        .halted(halted2), .fetch_count(fetch_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", id_valid); end
        n_checks++; if (id_instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h want 00000013", id_instruction); end
        n_checks++; if (id_pc !== 10'd0) begin n_fail++; $display("FAIL reset_idpc got %0d want 0", id_pc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        n_checks++; if (imem_pc !== 10'd0) begin n_fail++; $display("FAIL reset_imempc got %0d want 0", imem_pc); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || imem_pc !== 10'd0) begin n_fail++; $display("FAIL idle_hold valid %b pc %0d want 0 0", id_valid, imem_pc); end
        exp_fc = 0;
    endtask

    task automatic test_sequence();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            exp_fc++;
            n_checks++; if (id_pc !== 10'(k) || id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_pc[%0d] got %0d/%b want %0d/1", k, id_pc, id_valid, k); end
            n_checks++; if (id_instruction !== mem[k]) begin n_fail++; $display("FAIL seq_instr[%0d] got %h want %h", k, id_instruction, mem[k]); end
            n_checks++; if (halted !== (k == 6)) begin n_fail++; $display("FAIL seq_halted[%0d] got %b want %b", k, halted, (k == 6)); end
        end
        n_checks++; if (fetch_count !== 16'd7) begin n_fail++; $display("FAIL seq_count got %0d want 7", fetch_count); end
        n_checks++; if (fetch_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d want 3", fetch_count2); end
        n_checks++; if (imem_pc !== 10'd6) begin n_fail++; $display("FAIL halt_pc got %0d want 6", imem_pc); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || halted !== 1'b1 || imem_pc !== 10'd6) begin n_fail++; $display("FAIL halt_bubble valid %b halted %b pc %0d want 0 1 6", id_valid, halted, imem_pc); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (halted !== 1'b1 || fetch_count !== 16'd7) begin n_fail++; $display("FAIL halt_start halted %b count %0d want 1 7", halted, fetch_count); end
    endtask

    task automatic test_halt_redirect();
        redirect_valid = 1'b1; redirect_pc = 10'd1;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (halted !== 1'b0 || id_valid !== 1'b0 || imem_pc !== 10'd1) begin n_fail++; $display("FAIL halt_redir halted %b valid %b pc %0d want 0 0 1", halted, id_valid, imem_pc); end
        tick(); exp_fc++;
        n_checks++; if (id_pc !== 10'd1 || id_valid !== 1'b1 || id_instruction !== mem[1]) begin n_fail++; $display("FAIL halt_resume pc %0d valid %b instr %h want 1 1 %h", id_pc, id_valid, id_instruction, mem[1]); end
    endtask

    task automatic test_stall();
        tick(); exp_fc++;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (id_pc !== 10'd2 || id_valid !== 1'b1 || imem_pc !== 10'd3 || id_instruction !== mem[2]) begin n_fail++; $display("FAIL stall[%0d] idpc %0d imem %0d want 2 3", k, id_pc, imem_pc); end
        end
        n_checks++; if (fetch_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL stall_count got %0d want %0d", fetch_count, exp_fc); end
        stall = 1'b0;
        tick(); exp_fc++;
        n_checks++; if (id_pc !== 10'd3 || id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release idpc %0d valid %b want 3 1", id_pc, id_valid); end
    endtask

    task automatic test_redirect_stall();
        n_checks++; if (imem_pc !== 10'd4) begin n_fail++; $display("FAIL redir_pre imem %0d want 4", imem_pc); end
        redirect_valid = 1'b1; redirect_pc = 10'd0; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0000_0013 || imem_pc !== 10'd0) begin n_fail++; $display("FAIL redir_flush valid %b instr %h imem %0d want 0 00000013 0", id_valid, id_instruction, imem_pc); end
        tick(); exp_fc++;
        n_checks++; if (id_pc !== 10'd0 || id_valid !== 1'b1 || id_instruction !== mem[0]) begin n_fail++; $display("FAIL redir_target idpc %0d valid %b want 0 1", id_pc, id_valid); end
        n_checks++; if (fetch_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL redir_count got %0d want %0d", fetch_count, exp_fc); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 10'd1023;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_pc !== 10'd1023) begin n_fail++; $display("FAIL wrap_preload imem %0d want 1023", imem_pc); end
        tick(); exp_fc++;
        n_checks++; if (id_pc !== 10'd1023 || id_valid !== 1'b1 || imem_pc !== 10'd0) begin n_fail++; $display("FAIL wrap_last idpc %0d imem %0d want 1023 0", id_pc, imem_pc); end
        tick(); exp_fc++;
        n_checks++; if (id_pc !== 10'd0 || id_instruction !== mem[0] || imem_pc !== 10'd1) begin n_fail++; $display("FAIL wrap_first idpc %0d imem %0d want 0 1", id_pc, imem_pc); end
    endtask

    task automatic test_reset_mid_run();
        tick(); exp_fc++;
        tick(); exp_fc++;
        n_checks++; if (imem_pc !== 10'd3 || id_valid !== 1'b1 || id_pc !== 10'd2) begin n_fail++; $display("FAIL midrun_pre imem %0d valid %b want 3 1", imem_pc, id_valid); end
        n_checks++; if (fetch_count !== 16'(exp_fc) || fetch_count2 !== 2'd3) begin n_fail++; $display("FAIL midrun_count got %0d/%0d want %0d/3", fetch_count, fetch_count2, exp_fc); end
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0000_0013 || id_pc !== 10'd0 || imem_pc !== 10'd0) begin n_fail++; $display("FAIL midrun_reset valid %b instr %h idpc %0d imem %0d want 0 00000013 0 0", id_valid, id_instruction, id_pc, imem_pc); end
        n_checks++; if (halted !== 1'b0 || fetch_count !== 16'd0 || fetch_count2 !== 2'd0) begin n_fail++; $display("FAIL midrun_reset_cnt halted %b count %0d/%0d want 0 0/0", halted, fetch_count, fetch_count2); end
        tick();
        tick();
        n_checks++; if (id_valid !== 1'b0 || imem_pc !== 10'd0 || fetch_count !== 16'd0) begin n_fail++; $display("FAIL midrun_idle valid %b imem %0d count %0d want 0 0 0", id_valid, imem_pc, fetch_count); end
        n_checks++; if (id_valid2 !== 1'b0 || halted2 !== 1'b0 || id_pc2 !== 10'd0 || id_instruction2 !== 32'h0000_0013) begin n_fail++; $display("FAIL sat_idle valid %b halted %b want 0 0", id_valid2, halted2); end
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++)
            mem[i] = 32'h0000_0093 | (32'(i) << 20);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0030_0113;
        mem[2] = 32'h0020_81b3;
        mem[3] = 32'h0011_8213;
        mem[4] = 32'h0032_0233;
        mem[5] = 32'h0000_0013;
        mem[6] = 32'h0010_0073;

        test_reset();
        test_sequence();
        test_halt_redirect();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
